// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator. A pixel prescaler divides the system
//   clock down to the pixel rate. Horizontal and vertical counters walk the
//   raster. Sync, display-enable and the line/frame strobes are registered
//   together with the counters, so every output describes the same pixel.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   run          1 = advance, 0 = freeze all state (strobes/pix_en forced 0)
//   pix_en       pulse on the clock whose edge advances the pixel position
//   hpos, vpos   current column / line
//   hsync, vsync sync pulses, at H_POL / V_POL level while asserted
//   display_on   1 inside the visible window
//   line_start   1 for the cycle after hpos wrapped to 0
//   frame_start  1 for the cycle after hpos and vpos both wrapped to 0
//   frame_cnt    completed frames, wraps modulo 2^FRAME_W
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FRONT  = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BACK   = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned PIX_DIV  = 1,
   parameter int unsigned CNT_W    = 10,
   parameter int unsigned FRAME_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   output logic               pix_en,
   output logic [CNT_W-1:0]   hpos,
   output logic [CNT_W-1:0]   vpos,
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FRONT;
   localparam int unsigned H_SYNC_END = H_ACTIVE + H_FRONT + H_SYNC;
   localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FRONT;
   localparam int unsigned V_SYNC_END = V_ACTIVE + V_FRONT + V_SYNC;

   localparam int unsigned PRE_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PIX_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

   // Reject configurations the counters cannot represent.
   if (PIX_DIV < 1 || 64'(H_TOTAL) > (64'd1 << CNT_W) ||
       64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_param_check
      $error("vga_timing_gen: illegal PIX_DIV or CNT_W too narrow for totals");
   end

   logic [PRE_W-1:0]   pre_q,   pre_d;
   logic [CNT_W-1:0]   hpos_q,  hpos_d;
   logic [CNT_W-1:0]   vpos_q,  vpos_d;
   logic [FRAME_W-1:0] fcnt_q,  fcnt_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               disp_q,  disp_d;
   logic               line_q,  line_d;
   logic               frame_q, frame_d;

   logic pix_tick;
   logic advance;
   logic h_wrap;
   logic v_wrap;

   always_comb begin
      // NOTE: every next-state value gets a default first, so no path through
      // this block leaves a variable unassigned and no latch is inferred.
      pre_d  = pre_q;
      hpos_d = hpos_q;
      vpos_d = vpos_q;
      fcnt_d = fcnt_q;

      pix_tick = (pre_q == PRE_LAST);
      advance  = run & pix_tick;
      h_wrap   = (hpos_q == H_LAST);
      v_wrap   = (vpos_q == V_LAST);

      if (run) begin
         pre_d = pix_tick ? '0 : pre_q + 1'b1;
      end

      if (advance) begin
         hpos_d = h_wrap ? '0 : hpos_q + 1'b1;
         if (h_wrap) begin
            vpos_d = v_wrap ? '0 : vpos_q + 1'b1;
            if (v_wrap) begin
               fcnt_d = fcnt_q + 1'b1;
            end
         end
      end

      // Strobes only live for the cycle right after the wrapping advance;
      // any other edge (including a frozen one) clears them.
      line_d  = advance & h_wrap;
      frame_d = advance & h_wrap & v_wrap;

      // Decoded from the next position, so when the counters are frozen
      // these recompute to their current values and simply hold.
      hsync_d = (32'(hpos_d) >= H_SYNC_BEG && 32'(hpos_d) < H_SYNC_END) ? H_POL : ~H_POL;
      vsync_d = (32'(vpos_d) >= V_SYNC_BEG && 32'(vpos_d) < V_SYNC_END) ? V_POL : ~V_POL;
      disp_d  = (32'(hpos_d) < H_ACTIVE) && (32'(vpos_d) < V_ACTIVE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (!rst_n) begin
         pre_q   <= '0;
         hpos_q  <= '0;
         vpos_q  <= '0;
         fcnt_q  <= '0;
         hsync_q <= ~H_POL;
         vsync_q <= ~V_POL;
         disp_q  <= 1'b1;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         hpos_q  <= hpos_d;
         vpos_q  <= vpos_d;
         fcnt_q  <= fcnt_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         disp_q  <= disp_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

   // pix_en and the strobes are masked while frozen or held in reset.
   assign pix_en      = advance & rst_n;
   assign line_start  = line_q & run;
   assign frame_start = frame_q & run;

   assign hpos       = hpos_q;
   assign vpos       = vpos_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign display_on = disp_q;
   assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three generators share clk/rst_n/run:
//     A: 8/2/3/3 x 4/1/1/2, PIX_DIV=1, FRAME_W=2
//     B: same raster, PIX_DIV=3, active-high syncs
//     C: default 640x480
//   Reference: the position is derived arithmetically from the number of
//   run edges since reset (pixels = run_edges / PIX_DIV, split by totals).
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n;
   logic run;

   always #5 clk = ~clk;

   logic       a_pix, a_hs, a_vs, a_de, a_ls, a_fs;
   logic [9:0] a_h, a_v;
   logic [1:0] a_fc;
   logic       b_pix, b_hs, b_vs, b_de, b_ls, b_fs;
   logic [9:0] b_h, b_v;
   logic [7:0] b_fc;
   logic       c_pix, c_hs, c_vs, c_de, c_ls, c_fs;
   logic [9:0] c_h, c_v;
   logic [7:0] c_fc;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
      .PIX_DIV(1), .FRAME_W(2)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .run(run), .pix_en(a_pix),
      .hpos(a_h), .vpos(a_v), .hsync(a_hs), .vsync(a_vs),
      .display_on(a_de), .line_start(a_ls), .frame_start(a_fs),
      .frame_cnt(a_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
      .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(3)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .run(run), .pix_en(b_pix),
      .hpos(b_h), .vpos(b_v), .hsync(b_hs), .vsync(b_vs),
      .display_on(b_de), .line_start(b_ls), .frame_start(b_fs),
      .frame_cnt(b_fc)
   );

   vga_timing_gen u_c (
      .clk(clk), .rst_n(rst_n), .run(run), .pix_en(c_pix),
      .hpos(c_h), .vpos(c_v), .hsync(c_hs), .vsync(c_vs),
      .display_on(c_de), .line_start(c_ls), .frame_start(c_fs),
      .frame_cnt(c_fc)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference bookkeeping: run edges since the last reset edge, and whether
   // the most recent edge was a run edge.
   int unsigned run_edges = 0;
   bit          last_edge_run = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         run_edges     = 0;
         last_edge_run = 1'b0;
      end else begin
         last_edge_run = run;
         if (run) run_edges++;
      end
   end

   task automatic check_cfg(
      input string nm,
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb,
      input bit hpol, input bit vpol, input int div, input int fw,
      input logic o_pix, input int o_h, input int o_v,
      input logic o_hs, input logic o_vs, input logic o_de,
      input logic o_ls, input logic o_fs, input int o_fc);
      int ht, vt, pixels, eh, ev, efc;
      bit adv_last, e_pix, e_hs, e_vs, e_de, e_ls, e_fs;
      ht     = ha + hf + hs + hb;
      vt     = va + vf + vs + vb;
      pixels = int'(run_edges) / div;
      eh     = pixels % ht;
      ev     = (pixels / ht) % vt;
      efc    = (pixels / (ht * vt)) % (1 << fw);
      e_pix  = rst_n && run && ((int'(run_edges) % div) == div - 1);
      adv_last = last_edge_run && run_edges > 0 && (int'(run_edges) % div) == 0;
      e_ls   = run && adv_last && eh == 0;
      e_fs   = e_ls && ev == 0;
      e_de   = (eh < ha) && (ev < va);
      e_hs   = (eh >= ha + hf && eh < ha + hf + hs) ? hpol : !hpol;
      e_vs   = (ev >= va + vf && ev < va + vf + vs) ? vpol : !vpol;
      check({nm, "_pix_en"},      int'(o_pix), int'(e_pix));
      check({nm, "_hpos"},        o_h,         eh);
      check({nm, "_vpos"},        o_v,         ev);
      check({nm, "_hsync"},       int'(o_hs),  int'(e_hs));
      check({nm, "_vsync"},       int'(o_vs),  int'(e_vs));
      check({nm, "_display_on"},  int'(o_de),  int'(e_de));
      check({nm, "_line_start"},  int'(o_ls),  int'(e_ls));
      check({nm, "_frame_start"}, int'(o_fs),  int'(e_fs));
      check({nm, "_frame_cnt"},   o_fc,        efc);
   endtask

   // Advance to the next negedge and compare all three generators.
   task automatic step();
      @(negedge clk);
      check_cfg("A", 8, 2, 3, 3, 4, 1, 1, 2, 1'b0, 1'b0, 1, 2,
                a_pix, int'(a_h), int'(a_v), a_hs, a_vs, a_de, a_ls, a_fs, int'(a_fc));
      check_cfg("B", 8, 2, 3, 3, 4, 1, 1, 2, 1'b1, 1'b1, 3, 8,
                b_pix, int'(b_h), int'(b_v), b_hs, b_vs, b_de, b_ls, b_fs, int'(b_fc));
      check_cfg("C", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1, 8,
                c_pix, int'(c_h), int'(c_v), c_hs, c_vs, c_de, c_ls, c_fs, int'(c_fc));
   endtask

   int found, de_cnt, ls_cnt, hs_low, vs_low;
   int fc_seq[$];
   int exp_seq[5] = '{1, 2, 3, 0, 1};

   initial begin
      rst_n = 1'b0;
      run   = 1'b0;
      repeat (2) step();
      check("rst_a_hsync_idle", int'(a_hs), 1);
      check("rst_b_hsync_idle", int'(b_hs), 0);
      check("rst_a_display_on", int'(a_de), 1);

      // Free run: measure one full frame of A starting at its frame_start.
      rst_n = 1'b1;
      run   = 1'b1;
      found = 0;
      for (int i = 0; i < 200 && found == 0; i++) begin
         step();
         if (a_fs) found = 1;
      end
      check("wait_a_frame_start", found, 1);
      de_cnt = 0; ls_cnt = 0; hs_low = 0; vs_low = 0;
      for (int i = 0; i < 128; i++) begin
         de_cnt += int'(a_de);
         ls_cnt += int'(a_ls);
         hs_low += int'(!a_hs);
         vs_low += int'(!a_vs);
         step();
      end
      check("a_active_per_frame", de_cnt, 32);
      check("a_lines_per_frame",  ls_cnt, 8);
      check("a_hsync_low_clks",   hs_low, 24);
      check("a_vsync_low_clks",   vs_low, 16);

      // Random run/freeze with occasional resets.
      for (int i = 0; i < 600; i++) begin
         run   = ($urandom_range(3, 0) != 0);
         rst_n = ($urandom_range(49, 0) != 0);
         step();
      end

      // Freeze at hpos=5 for 10 clocks, then resume.
      rst_n = 1'b1;
      run   = 1'b1;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         step();
         if (a_h == 10'd5) found = 1;
      end
      check("wait_a_hpos5", found, 1);
      run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("freeze_a_hpos", int'(a_h), 5);
         check("freeze_a_pix_en", int'(a_pix), 0);
         check("freeze_a_line_start", int'(a_ls), 0);
      end
      run = 1'b1;
      step();
      check("resume_a_hpos", int'(a_h), 6);

      // Reset in the middle of hsync.
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         step();
         if (a_h == 10'd11) found = 1;
      end
      check("wait_a_hpos11", found, 1);
      check("a_hsync_at_11", int'(a_hs), 0);
      rst_n = 1'b0;
      step();
      check("midrst_a_hpos", int'(a_h), 0);
      check("midrst_a_vpos", int'(a_v), 0);
      check("midrst_a_hsync", int'(a_hs), 1);
      check("midrst_a_frame_cnt", int'(a_fc), 0);

      // Five frames of A: 2-bit frame counter must wrap.
      rst_n = 1'b1;
      for (int i = 0; i < 700; i++) begin
         step();
         if (a_fs) fc_seq.push_back(int'(a_fc));
      end
      check("a_frames_seen", int'(fc_seq.size() >= 5), 1);
      for (int i = 0; i < 5; i++) begin
         if (i < fc_seq.size()) check("a_frame_cnt_seq", fc_seq[i], exp_seq[i]);
      end

      // One full 800-pixel line of C.
      found = 0;
      for (int i = 0; i < 900 && found == 0; i++) begin
         step();
         if (c_ls) found = 1;
      end
      check("wait_c_line_start", found, 1);
      hs_low = 0; ls_cnt = 0;
      for (int i = 0; i < 800; i++) begin
         if (!c_hs) begin
            hs_low++;
            if (hs_low == 1) check("c_hsync_first_low_hpos", int'(c_h), 656);
         end
         ls_cnt += int'(c_ls);
         step();
      end
      check("c_hsync_low_clks", hs_low, 96);
      check("c_lines_in_800", ls_cnt, 1);
      check("c_line_start_after_800", int'(c_ls), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
